// File: rtl/rv32_dbus_pkg.sv
// rtl/rv32_dbus_pkg.sv - shared types and constants for the RV32 data bus responder
package rv32_dbus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RAM_RD = 1'b1
    } dbus_state_t;

    localparam logic [7:0] OFF_LEDS        = 8'h00;
    localparam logic [7:0] OFF_SCRATCH     = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h0C;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h10;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h14;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32_dbus_if.sv
// rtl/rv32_dbus_if.sv - core data bus signals between memory stage and responder
interface rv32_dbus_if;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_address_in;
    logic [31:0] data_write_value_in;
    logic        data_ready_out;
    logic [31:0] data_read_value_out;

    modport master (
        output data_read_in, data_write_in, data_write_mask_in,
               data_address_in, data_write_value_in,
        input  data_ready_out, data_read_value_out
    );

    modport slave (
        input  data_read_in, data_write_in, data_write_mask_in,
               data_address_in, data_write_value_in,
        output data_ready_out, data_read_value_out
    );
endinterface

// File: rtl/rv32_dbus_ram.sv
// rtl/rv32_dbus_ram.sv - single-port byte-enabled RAM with registered read, contents not reset
module rv32_dbus_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/rv32_data_bus_responder.sv
// rtl/rv32_data_bus_responder.sv - RAM/MMIO responder for the RV32 data bus
// Optional machine timer enabled by defining RV32_DBUS_TIMER_EN.
module rv32_data_bus_responder
    import rv32_dbus_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    rv32_dbus_if.slave  bus,
    output logic [7:0]  leds_out,
    output logic        timer_irq_out,
    output logic        bus_error_out
);

    localparam int AW = $clog2(RAM_WORDS);

    dbus_state_t state;
    logic        in_idle, req, rd_only, ram_hit, mmio_hit, err_now;
    logic        ram_rd_start, ram_wr, mmio_wr;
    logic [7:0]  mmio_off;
    logic [31:0] mmio_rdata, ram_rdata, scratch_q;
    logic [7:0]  leds_q;
    logic        bus_error_q;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, bus.data_address_in[1:0]};

    assign req      = bus.data_read_in | bus.data_write_in;
    assign rd_only  = bus.data_read_in & ~bus.data_write_in;
    assign ram_hit  = bus.data_address_in[31:AW+2] == RAM_BASE[31:AW+2];
    assign mmio_hit = ~ram_hit && (bus.data_address_in[31:8] == MMIO_BASE[31:8]);
    assign mmio_off = {bus.data_address_in[7:2], 2'b00};

    // Gating with reset keeps the bus quiet and state untouched while reset is held.
    assign in_idle      = (state == IDLE) && !reset;
    assign ram_rd_start = in_idle && rd_only && ram_hit;
    assign ram_wr       = in_idle && bus.data_write_in && ram_hit;
    assign mmio_wr      = in_idle && bus.data_write_in && mmio_hit;
    assign err_now      = in_idle && req &&
                          ((bus.data_read_in && bus.data_write_in) || !(ram_hit || mmio_hit));

    rv32_dbus_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .addr  (bus.data_address_in[AW+1:2]),
        .re    (ram_rd_start),
        .we    (ram_wr ? bus.data_write_mask_in : 4'b0000),
        .wdata (bus.data_write_value_in),
        .rdata (ram_rdata)
    );

`ifdef RV32_DBUS_TIMER_EN
    logic [63:0] mtime_q, mtimecmp_q;
    logic        timer_irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RESET;
            timer_irq_q <= 1'b0;
        end else begin
            timer_irq_q <= mtime_q >= mtimecmp_q;
            // A software write to either mtime half replaces that cycle's increment.
            if (mmio_wr && mmio_off == OFF_MTIME_LO)
                mtime_q[31:0] <= merge_bytes(mtime_q[31:0], bus.data_write_value_in,
                                             bus.data_write_mask_in);
            else if (mmio_wr && mmio_off == OFF_MTIME_HI)
                mtime_q[63:32] <= merge_bytes(mtime_q[63:32], bus.data_write_value_in,
                                              bus.data_write_mask_in);
            else
                mtime_q <= mtime_q + 64'd1;
            if (mmio_wr && mmio_off == OFF_MTIMECMP_LO)
                mtimecmp_q[31:0] <= merge_bytes(mtimecmp_q[31:0], bus.data_write_value_in,
                                                bus.data_write_mask_in);
            if (mmio_wr && mmio_off == OFF_MTIMECMP_HI)
                mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], bus.data_write_value_in,
                                                 bus.data_write_mask_in);
        end
    end

    assign timer_irq_out = timer_irq_q;
`else
    assign timer_irq_out = 1'b0;
`endif

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_LEDS:        mmio_rdata = {24'h0, leds_q};
            OFF_SCRATCH:     mmio_rdata = scratch_q;
`ifdef RV32_DBUS_TIMER_EN
            OFF_MTIME_LO:    mmio_rdata = mtime_q[31:0];
            OFF_MTIME_HI:    mmio_rdata = mtime_q[63:32];
            OFF_MTIMECMP_LO: mmio_rdata = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: mmio_rdata = mtimecmp_q[63:32];
`endif
            default:         mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bus_error_q <= 1'b0;
            leds_q      <= '0;
            scratch_q   <= '0;
        end else begin
            case (state)
                IDLE:   if (ram_rd_start) state <= RAM_RD;
                RAM_RD: state <= IDLE;
            endcase
            if (err_now) bus_error_q <= 1'b1;
            if (mmio_wr && mmio_off == OFF_LEDS && bus.data_write_mask_in[0])
                leds_q <= bus.data_write_value_in[7:0];
            if (mmio_wr && mmio_off == OFF_SCRATCH)
                scratch_q <= merge_bytes(scratch_q, bus.data_write_value_in,
                                         bus.data_write_mask_in);
        end
    end

    // RAM_RD completes even if the requester has let go of the request.
    assign bus.data_ready_out = !reset &&
                                ((state == RAM_RD) || (in_idle && req && !ram_rd_start));

    assign bus.data_read_value_out =
        (!reset && state == RAM_RD)       ? ram_rdata  :
        (in_idle && rd_only && mmio_hit)  ? mmio_rdata : 32'h0;

    assign leds_out      = leds_q;
    assign bus_error_out = bus_error_q;

endmodule

// File: tb/tb_rv32_data_bus_responder.sv
// tb/tb_rv32_data_bus_responder.sv - vector table, corner sequences and random model check
module tb_rv32_data_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] leds;
    logic       irq;
    logic       err;

    rv32_dbus_if bus ();

    rv32_data_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .leds_out      (leds),
        .timer_irq_out (irq),
        .bus_error_out (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rv;
        logic [7:0]  leds;
        logic        err;
    } vec_t;

    vec_t        tab[$];
    int          total = 0;
    int          bad = 0;
    int          lat;
    logic [31:0] rv;
    logic [31:0] mdl_ram [16];
    logic [7:0]  mdl_leds;
    logic [31:0] mdl_scr;
    logic        mdl_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.data_read_in        = rd;
        bus.data_write_in       = wr;
        bus.data_write_mask_in  = m;
        bus.data_address_in     = a;
        bus.data_write_value_in = wd;
    endtask

    // Called just after a rising edge; returns with the request still driven.
    task automatic access(input logic rd, input logic wr, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat_o, output logic [31:0] rv_o);
        drive(rd, wr, m, a, wd);
        lat_o = 0;
        rv_o  = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.data_ready_out) begin
                lat_o = c;
                rv_o  = bus.data_read_value_out;
            end else begin
                chk("rdata_zero_when_not_ready", bus.data_read_value_out, 32'h0);
            end
            @(posedge clk);
            #1;
            if (lat_o != 0) break;
        end
        if (lat_o == 0) chk("ready_timeout", 32'(lat_o), 32'd1);
    endtask

    function automatic logic [31:0] apply_mask(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic add(input logic rd, input logic wr, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] wd, input int l,
                       input logic [31:0] r, input logic [7:0] ld, input logic e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m = m; v.a = a; v.wd = wd;
        v.lat = l; v.rv = r; v.leds = ld; v.err = e;
        tab.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;

        add(0, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0,         8'h00, 0);
        add(1, 0, 4'h0, 32'h0000_0010, 32'h0,         2, 32'hDEAD_BEEF, 8'h00, 0);
        add(0, 1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 1, 32'h0,         8'h00, 0);
        add(1, 0, 4'h0, 32'h0000_0010, 32'h0,         2, 32'hDEAA_BEEF, 8'h00, 0);
        add(0, 1, 4'h1, 32'hF000_0000, 32'h0000_005A, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'hF000_0000, 32'h0,         1, 32'h0000_005A, 8'h5A, 0);
        add(0, 1, 4'hE, 32'hF000_0000, 32'hFFFF_FFFF, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'hF000_0000, 32'h0,         1, 32'h0000_005A, 8'h5A, 0);
        add(0, 1, 4'hF, 32'hF000_0004, 32'h1234_5678, 1, 32'h0,         8'h5A, 0);
        add(0, 1, 4'h2, 32'hF000_0004, 32'hFFFF_FFFF, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'hF000_0004, 32'h0,         1, 32'h1234_FF78, 8'h5A, 0);
        add(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'h0000_0012, 32'h0,         2, 32'hDEAA_BEEF, 8'h5A, 0);
        add(0, 1, 4'hF, 32'hF000_0018, 32'hFFFF_FFFF, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'hF000_0018, 32'h0,         1, 32'h0,         8'h5A, 0);
        add(0, 1, 4'hF, 32'h0000_0FFC, 32'h1122_3344, 1, 32'h0,         8'h5A, 0);
        add(1, 0, 4'h0, 32'h0000_0FFE, 32'h0,         2, 32'h1122_3344, 8'h5A, 0);
        add(1, 0, 4'h0, 32'h0000_1000, 32'h0,         1, 32'h0,         8'h5A, 1);
        add(1, 0, 4'h0, 32'h4000_0000, 32'h0,         1, 32'h0,         8'h5A, 1);
        add(1, 1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0,         8'h5A, 1);
        add(1, 0, 4'h0, 32'h0000_0020, 32'h0,         2, 32'hCAFE_F00D, 8'h5A, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(bus.data_ready_out), 32'd0);
        chk("reset_rdata", bus.data_read_value_out, 32'h0);
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tab[i]) begin
            access(tab[i].rd, tab[i].wr, tab[i].m, tab[i].a, tab[i].wd, lat, rv);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tab[i].lat));
            chk($sformatf("vec%0d_rdata", i), rv, tab[i].rv);
            chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(tab[i].leds));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tab[i].err));
        end

        // Requester abandons a RAM read while it is in its wait state.
        drive(1, 0, 4'h0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("abandon_wait_ready", 32'(bus.data_ready_out), 32'd0);
        @(posedge clk);
        #1 drive(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abandon_pulse_ready", 32'(bus.data_ready_out), 32'd1);
        chk("abandon_pulse_rdata", bus.data_read_value_out, 32'hDEAA_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abandon_back_idle", 32'(bus.data_ready_out), 32'd0);
        @(posedge clk);
        #1;

`ifdef RV32_DBUS_TIMER_EN
        access(0, 1, 4'hF, 32'hF000_0014, 32'h0, lat, rv);
        access(1, 0, 4'h0, 32'hF000_0008, 32'h0, lat, rv);
        chk("mtime_read_latency", 32'(lat), 32'd1);
        access(0, 1, 4'hF, 32'hF000_0010, rv + 32'd20, lat, rv);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            chk($sformatf("timer_irq_cycle%0d", j), 32'(irq), (j >= 20) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
`else
        access(0, 1, 4'hF, 32'hF000_0010, 32'h0, lat, rv);
        access(1, 0, 4'h0, 32'hF000_0010, 32'h0, lat, rv);
        chk("timer_off_cmp_reads0", rv, 32'h0);
        access(1, 0, 4'h0, 32'hF000_0008, 32'h0, lat, rv);
        chk("timer_off_mtime_reads0", rv, 32'h0);
        chk("timer_off_irq", 32'(irq), 32'd0);
`endif

        // Reset asserted while a RAM read sits in its wait state.
        drive(1, 0, 4'h0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_rd_ready", 32'(bus.data_ready_out), 32'd0);
        chk("rst_rd_rdata", bus.data_read_value_out, 32'h0);
        chk("rst_rd_leds", 32'(leds), 32'h0);
        chk("rst_rd_err", 32'(err), 32'd0);
        chk("rst_rd_irq", 32'(irq), 32'd0);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_rd_no_pulse", 32'(bus.data_ready_out), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        access(1, 0, 4'h0, 32'h0000_0010, 32'h0, lat, rv);
        chk("post_rst_read_latency", 32'(lat), 32'd2);
        chk("post_rst_read_rdata", rv, 32'hDEAA_BEEF);
        access(1, 0, 4'h0, 32'hF000_0004, 32'h0, lat, rv);
        chk("post_rst_scratch", rv, 32'h0);

        // Randomised traffic against a behavioural model.
        mdl_leds = 8'h00;
        mdl_scr  = 32'h0;
        mdl_err  = 1'b0;
        for (int w = 0; w < 16; w++) begin
            mdl_ram[w] = $urandom;
            access(0, 1, 4'hF, 32'h100 + 32'(w) * 4, mdl_ram[w], lat, rv);
        end
        for (int n = 0; n < 200; n++) begin
            int          kind, w, tgt, exp_lat;
            logic        rd, wr;
            logic [3:0]  m;
            logic [31:0] a, wd, exp_rv;
            kind = $urandom_range(0, 19);
            rd   = 1'($urandom_range(0, 1));
            wr   = !rd;
            m    = 4'($urandom);
            wd   = $urandom;
            w    = $urandom_range(0, 15);
            tgt  = 0;
            a    = 32'h100 + 32'(w) * 4 + 32'($urandom_range(0, 3));
            if (kind == 19) begin
                rd = 1'b1;
                wr = 1'b1;
            end else if (kind >= 12 && kind < 15) begin
                tgt = 1; a = 32'hF000_0000;
            end else if (kind >= 15 && kind < 17) begin
                tgt = 2; a = 32'hF000_0004;
            end else if (kind == 17) begin
                tgt = 3; a = 32'hF000_0018 + 32'($urandom_range(0, 57)) * 4;
            end else if (kind == 18) begin
                tgt = 4; a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
            end
            exp_lat = (rd && !wr && tgt == 0) ? 2 : 1;
            exp_rv  = 32'h0;
            if (rd && !wr) begin
                case (tgt)
                    0: exp_rv = mdl_ram[w];
                    1: exp_rv = {24'h0, mdl_leds};
                    2: exp_rv = mdl_scr;
                    default: exp_rv = 32'h0;
                endcase
            end
            if (wr) begin
                case (tgt)
                    0: mdl_ram[w] = apply_mask(mdl_ram[w], wd, m);
                    1: if (m[0]) mdl_leds = wd[7:0];
                    2: mdl_scr = apply_mask(mdl_scr, wd, m);
                    default: ;
                endcase
            end
            if ((rd && wr) || tgt == 4) mdl_err = 1'b1;
            access(rd, wr, m, a, wd, lat, rv);
            chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat));
            chk($sformatf("rand%0d_rdata", n), rv, exp_rv);
            chk($sformatf("rand%0d_leds", n), 32'(leds), 32'(mdl_leds));
            chk($sformatf("rand%0d_err", n), 32'(err), 32'(mdl_err));
        end
        drive(0, 0, 4'h0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
